// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter
//  Description : Two-requester round-robin arbiter in front of a single SRAM
//                controller. Issues one command pulse per access, tracks the
//                controller's busy/idle handshake, and aborts with err on a
//                wait timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter logic [1:0]  CTL_IDLE    = 2'b00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req,
  input  logic       a_we,
  input  logic [3:0] a_addr,
  input  logic [3:0] a_wdata,
  input  logic       b_req,
  input  logic       b_we,
  input  logic [3:0] b_addr,
  input  logic [3:0] b_wdata,
  output logic       a_gnt,
  output logic       b_gnt,
  output logic       a_done,
  output logic       b_done,
  output logic [3:0] rdata,
  output logic       err,
  output logic       ctl_write,
  output logic       ctl_read,
  output logic [3:0] ctl_addr,
  output logic [3:0] ctl_data,
  input  logic [3:0] ctl_rdata,
  input  logic [1:0] ctl_state
);

  localparam logic [2:0] c_IDLE      = 3'd0;
  localparam logic [2:0] c_ISSUE     = 3'd1;
  localparam logic [2:0] c_WAIT_BUSY = 3'd2;
  localparam logic [2:0] c_WAIT_IDLE = 3'd3;
  localparam logic [2:0] c_DONE      = 3'd4;

  // Last counter value tolerated in a wait state before the access is aborted.
  localparam logic [15:0] c_CNT_LAST = 16'(TIMEOUT_CYC - 1);

  logic [2:0]  r_state;
  logic [2:0]  w_state_nxt;

  logic        r_prio_b;     // 1: B wins a tie next time, 0: A wins
  logic        r_a_gnt;
  logic        r_b_gnt;
  logic        r_we;         // latched operation of the current access
  logic [3:0]  r_addr;
  logic [3:0]  r_data;
  logic [3:0]  r_rdata;
  logic        r_a_done;
  logic        r_b_done;
  logic        r_err;
  logic        r_ctl_write;
  logic        r_ctl_read;
  logic [15:0] r_cnt;

  logic        w_any_req;
  logic        w_pick_b;
  logic        w_pick_we;
  logic        w_ctl_busy;
  logic        w_cnt_expired;
  logic        w_abort;
  logic        w_enter_done;
  logic        w_enter_wait;
  logic        w_in_wait;
  logic        w_select;

  assign w_any_req     = a_req | b_req;
  assign w_ctl_busy    = (ctl_state != CTL_IDLE);
  assign w_cnt_expired = (r_cnt == c_CNT_LAST);
  assign w_in_wait     = (r_state == c_WAIT_BUSY) || (r_state == c_WAIT_IDLE);
  assign w_select      = (r_state == c_IDLE) && w_any_req;
  assign w_pick_we     = w_pick_b ? b_we : a_we;

  // Winner selection: a lone requester always wins, a tie goes to the pointer.
  always_comb begin
    w_pick_b = 1'b0;
    if (a_req && b_req) begin
      w_pick_b = r_prio_b;
    end else begin
      w_pick_b = b_req;
    end
  end

  // Next-state decode; a controller response takes precedence over a timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (w_any_req) begin
          w_state_nxt = c_ISSUE;
        end
      end
      c_ISSUE: begin
        w_state_nxt = c_WAIT_BUSY;
      end
      c_WAIT_BUSY: begin
        if (w_ctl_busy) begin
          w_state_nxt = c_WAIT_IDLE;
        end else if (w_cnt_expired) begin
          w_state_nxt = c_DONE;
        end
      end
      c_WAIT_IDLE: begin
        if (!w_ctl_busy || w_cnt_expired) begin
          w_state_nxt = c_DONE;
        end
      end
      c_DONE: begin
        w_state_nxt = c_IDLE;
      end
      default: begin
        w_state_nxt = c_IDLE;
      end
    endcase
  end

  // An abort is a DONE entry caused by the counter rather than the controller.
  assign w_abort = w_cnt_expired &&
                   (((r_state == c_WAIT_BUSY) && !w_ctl_busy) ||
                    ((r_state == c_WAIT_IDLE) &&  w_ctl_busy));

  assign w_enter_done = (r_state != c_DONE) && (w_state_nxt == c_DONE);
  assign w_enter_wait = (w_state_nxt != r_state) &&
                        ((w_state_nxt == c_WAIT_BUSY) || (w_state_nxt == c_WAIT_IDLE));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Grant ownership and round-robin pointer; the pointer moves only when an access finishes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_gnt  <= 1'b0;
      r_b_gnt  <= 1'b0;
      r_prio_b <= 1'b0;
    end else if (w_select) begin
      r_a_gnt <= !w_pick_b;
      r_b_gnt <=  w_pick_b;
    end else if (r_state == c_DONE) begin
      r_a_gnt  <= 1'b0;
      r_b_gnt  <= 1'b0;
      r_prio_b <= r_a_gnt;
    end
  end

  // Access operands are captured once at selection and frozen for the whole access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_addr <= 4'h0;
      r_data <= 4'h0;
    end else if (w_select) begin
      r_we   <= w_pick_we;
      r_addr <= w_pick_b ? b_addr  : a_addr;
      r_data <= w_pick_b ? b_wdata : a_wdata;
    end
  end

  // Single-cycle command pulses, asserted for the ISSUE cycle only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctl_write <= 1'b0;
      r_ctl_read  <= 1'b0;
    end else begin
      r_ctl_write <= w_select &&  w_pick_we;
      r_ctl_read  <= w_select && !w_pick_we;
    end
  end

  // Completion strobes and error flag, high only during the DONE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_done <= 1'b0;
      r_b_done <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_a_done <= w_enter_done && r_a_gnt;
      r_b_done <= w_enter_done && r_b_gnt;
      r_err    <= w_enter_done && w_abort;
    end
  end

  // Wait-state timeout counter: cleared when a wait state is entered, counts while waiting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= 16'h0000;
    end else if (w_enter_wait) begin
      r_cnt <= 16'h0000;
    end else if (w_in_wait && (w_state_nxt == r_state)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Read data is captured only on a normal read completion; writes and aborts keep it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= 4'h0;
    end else if ((r_state == c_WAIT_IDLE) && !w_ctl_busy && !r_we) begin
      r_rdata <= ctl_rdata;
    end
  end

  assign a_gnt     = r_a_gnt;
  assign b_gnt     = r_b_gnt;
  assign a_done    = r_a_done;
  assign b_done    = r_b_done;
  assign err       = r_err;
  assign rdata     = r_rdata;
  assign ctl_write = r_ctl_write;
  assign ctl_read  = r_ctl_read;
  assign ctl_addr  = r_addr;
  assign ctl_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_arbiter
//  Description : Directed scoreboard bench for sram_arbiter with a small
//                behavioural SRAM controller model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [3:0] a_addr = 4'h0, a_wdata = 4'h0, b_addr = 4'h0, b_wdata = 4'h0;
  logic       a_gnt, b_gnt, a_done, b_done, err, ctl_write, ctl_read;
  logic [3:0] rdata, ctl_addr, ctl_data;
  logic [3:0] ctl_rdata = 4'h0;
  logic [1:0] ctl_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_done = 0;

  // Controller model state
  int         busy_len  = 5;
  int         busy_left = 0;
  logic       stuck     = 1'b0;
  logic [3:0] mem [16]  = '{default: 4'h0};

  typedef struct {
    logic       who_b;
    logic       err;
    logic [3:0] rdata;
    int         cyc;
  } done_t;

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [3:0] data;
  } cmd_t;

  done_t done_q[$];
  cmd_t  cmd_q[$];

  sram_arbiter #(.TIMEOUT_CYC(8), .CTL_IDLE(2'b00)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .a_gnt     (a_gnt),
    .b_gnt     (b_gnt),
    .a_done    (a_done),
    .b_done    (b_done),
    .rdata     (rdata),
    .err       (err),
    .ctl_write (ctl_write),
    .ctl_read  (ctl_read),
    .ctl_addr  (ctl_addr),
    .ctl_data  (ctl_data),
    .ctl_rdata (ctl_rdata),
    .ctl_state (ctl_state)
  );

  always #50 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: a command starts busy_len busy cycles, then the state returns to 00.
  always @(posedge clk) begin
    if (ctl_write && !stuck) begin
      mem[ctl_addr] <= ctl_data;
      busy_left     <= busy_len;
    end else if (ctl_read && !stuck) begin
      ctl_rdata <= mem[ctl_addr];
      busy_left <= busy_len;
    end else if (busy_left > 0) begin
      busy_left <= busy_left - 1;
    end
  end
  assign ctl_state = (busy_left > 0) ? 2'b01 : 2'b00;

  // Monitor: compares every command pulse and completion against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (a_gnt && b_gnt) begin
        errors++;
        $display("FAIL gnt_overlap cyc=%0d a_gnt=%b b_gnt=%b required not both", cyc, a_gnt, b_gnt);
      end
      if (ctl_write || ctl_read) begin
        checks++;
        if (cmd_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_cmd cyc=%0d wr=%b rd=%b addr=%h data=%h required none", cyc, ctl_write, ctl_read, ctl_addr, ctl_data);
        end else begin
          cmd_t c;
          c = cmd_q.pop_front();
          if ({ctl_write, ctl_read, ctl_addr, ctl_data} !== {c.we, !c.we, c.addr, c.data}) begin
            errors++;
            $display("FAIL cmd cyc=%0d got wr=%b rd=%b addr=%h data=%h required wr=%b rd=%b addr=%h data=%h",
                     cyc, ctl_write, ctl_read, ctl_addr, ctl_data, c.we, !c.we, c.addr, c.data);
          end
        end
      end
      if (a_done || b_done) begin
        n_done++;
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done cyc=%0d a_done=%b b_done=%b required none", cyc, a_done, b_done);
        end else begin
          done_t d;
          d = done_q.pop_front();
          if ({a_done, b_done, a_gnt, b_gnt, err, rdata} !== {!d.who_b, d.who_b, !d.who_b, d.who_b, d.err, d.rdata}
              || cyc != d.cyc) begin
            errors++;
            $display("FAIL done cyc=%0d got done=%b%b gnt=%b%b err=%b rdata=%h required cyc=%0d done=%b%b gnt=%b%b err=%b rdata=%h",
                     cyc, a_done, b_done, a_gnt, b_gnt, err, rdata,
                     d.cyc, !d.who_b, d.who_b, !d.who_b, d.who_b, d.err, d.rdata);
          end
        end
      end
    end
  end

  task automatic push_done(input logic who_b, input logic e, input logic [3:0] rd, input int at);
    done_t d;
    d.who_b = who_b; d.err = e; d.rdata = rd; d.cyc = at;
    done_q.push_back(d);
  endtask

  task automatic push_cmd(input logic we, input logic [3:0] addr, input logic [3:0] data);
    cmd_t c;
    c.we = we; c.addr = addr; c.data = data;
    cmd_q.push_back(c);
  endtask

  task automatic wait_done(input int target, input string name);
    int budget = 100;
    while (n_done < target && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    checks++;
    if (n_done < target) begin
      errors++;
      $display("FAIL %s_timeout done_count=%0d required %0d", name, n_done, target);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({a_gnt, b_gnt, a_done, b_done, err, ctl_write, ctl_read, ctl_addr, ctl_data, rdata} !== 23'd0) begin
      errors++;
      $display("FAIL %s gnt=%b%b done=%b%b err=%b wr=%b rd=%b addr=%h data=%h rdata=%h required all 0",
               name, a_gnt, b_gnt, a_done, b_done, err, ctl_write, ctl_read, ctl_addr, ctl_data, rdata);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  int t0;
  int base;

  initial begin
    // Reset state
    gap(3);
    check_all_zero("reset_state");
    rst = 1'b0;
    gap(2);

    // 1: A write addr 3 data A, controller busy 5 cycles
    busy_len = 5;
    a_we = 1'b1; a_addr = 4'h3; a_wdata = 4'hA; a_req = 1'b1;
    t0 = cyc;
    push_cmd(1'b1, 4'h3, 4'hA);
    push_done(1'b0, 1'b0, 4'h0, t0 + 8);
    gap(1);
    checks++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      errors++;
      $display("FAIL a_gnt_next_cycle gnt=%b%b required 10", a_gnt, b_gnt);
    end
    a_addr = 4'hF; a_wdata = 4'h5;   // must be ignored mid-access
    wait_done(1, "s1");
    a_req = 1'b0;
    gap(4);

    // 2: B read addr 3, model returns A
    busy_len = 3;
    b_we = 1'b0; b_addr = 4'h3; b_wdata = 4'h0; b_req = 1'b1;
    t0 = cyc;
    push_cmd(1'b0, 4'h3, 4'h0);
    push_done(1'b1, 1'b0, 4'hA, t0 + 6);
    wait_done(2, "s2");
    b_req = 1'b0;
    gap(4);

    // 3: simultaneous requests held for four accesses -> A,B,A,B
    busy_len = 2;
    a_we = 1'b1; a_addr = 4'h5; a_wdata = 4'h1; a_req = 1'b1;
    b_we = 1'b1; b_addr = 4'h6; b_wdata = 4'h2; b_req = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push_cmd(1'b1, 4'h5, 4'h1);
      else            push_cmd(1'b1, 4'h6, 4'h2);
      push_done(k % 2 == 1, 1'b0, 4'hA, t0 + 5 + 6 * k);
    end
    wait_done(6, "s3");
    a_req = 1'b0; b_req = 1'b0;
    gap(4);

    // 4: controller stuck idle -> abort 8 cycles after entering WAIT_BUSY
    stuck = 1'b1;
    a_we = 1'b0; a_addr = 4'h7; a_wdata = 4'h0; a_req = 1'b1;
    t0 = cyc;
    push_cmd(1'b0, 4'h7, 4'h0);
    push_done(1'b0, 1'b1, 4'hA, t0 + 10);
    wait_done(7, "s4");
    a_req = 1'b0;
    gap(2);
    stuck = 1'b0;
    gap(2);

    // 5: reset during WAIT_IDLE, then a tie must go to A
    busy_len = 5;
    a_we = 1'b1; a_addr = 4'h9; a_wdata = 4'h3; a_req = 1'b1;
    t0 = cyc;
    push_cmd(1'b1, 4'h9, 4'h3);
    gap(4);
    rst = 1'b1;
    a_req = 1'b0;
    #1;
    check_all_zero("reset_mid_access");
    gap(1);
    rst = 1'b0;
    gap(8);
    checks++;
    if (n_done != 7) begin
      errors++;
      $display("FAIL no_done_after_reset done_count=%0d required 7", n_done);
    end
    busy_len = 2;
    a_we = 1'b1; a_addr = 4'h1; a_wdata = 4'h4; a_req = 1'b1;
    b_we = 1'b1; b_addr = 4'h2; b_wdata = 4'h5; b_req = 1'b1;
    t0 = cyc;
    push_cmd(1'b1, 4'h1, 4'h4);
    push_done(1'b0, 1'b0, 4'h0, t0 + 5);
    wait_done(8, "s5");
    a_req = 1'b0; b_req = 1'b0;
    gap(4);

    // 6: A drops req during WAIT_BUSY; access still completes, nothing further issued
    busy_len = 3;
    a_we = 1'b0; a_addr = 4'h5; a_wdata = 4'h0; a_req = 1'b1;
    t0 = cyc;
    push_cmd(1'b0, 4'h5, 4'h0);
    push_done(1'b0, 1'b0, 4'h1, t0 + 6);
    gap(2);
    a_req = 1'b0;
    wait_done(9, "s6");
    gap(12);

    checks++;
    if (cmd_q.size() != 0 || done_q.size() != 0) begin
      errors++;
      $display("FAIL queues_drained cmd_left=%0d done_left=%0d required 0 0", cmd_q.size(), done_q.size());
    end
    checks++;
    if ({a_gnt, b_gnt} !== 2'b00) begin
      errors++;
      $display("FAIL final_gnt gnt=%b%b required 00", a_gnt, b_gnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
